correlator_lag_core: RTL

- Parametrised successor of the single-lag correlator datapath.
- Synchronises NUM_INPUTS one-bit pulse inputs and samples them on a programmable tick.
- Counts pairwise coincidences at every lag 0..MAX_DELAY-1 over a programmable integration window.
- At each window end, snapshots all counters and streams them as a byte frame over a valid/ready handshake to the UART transmitter.

---
 rtl/correlator_pkg.sv | 26 ++
 rtl/correlator_lag_core_if.sv | 9 +
 rtl/correlator_frame_tx.sv | 93 +++++++++
 rtl/correlator_lag_core.sv | 121 ++++++++++++
 4 files changed

// File: rtl/correlator_pkg.sv
// Shared constants, readout state encoding and pair-indexing helpers for the lag correlator.
package correlator_pkg;

  localparam logic [7:0] FRAME_HEADER = 8'hA5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    FLAGS  = 2'd2,
    DATA   = 2'd3
  } rd_state_e;

  function automatic int num_pairs(input int n);
    return (n * (n - 1)) / 2;
  endfunction

  // Row-major position of pair (i,j), i<j: (0,1),(0,2)..(0,n-1),(1,2)..
  function automatic int pair_index(input int i, input int j, input int n);
    return i * n - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  function automatic int bytes_per_count(input int res);
    return (res + 7) / 8;
  endfunction

endpackage

// File: rtl/correlator_lag_core_if.sv
// Byte-stream valid/ready link from the correlator readout to the UART transmitter.
interface correlator_lag_core_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/correlator_frame_tx.sv
// Holds the window snapshot and serialises it as header, flags and MSB-first counter bytes.
module correlator_frame_tx
  import correlator_pkg::*;
#(
  parameter int NUM_CH     = 264,
  parameter int RESOLUTION = 16
) (
  input  logic                                clki,
  input  logic                                rst_n,
  input  logic                                i_load,
  input  logic [NUM_CH-1:0][RESOLUTION-1:0]   i_counts,
  output logic                                o_overrun,
  correlator_lag_core_if.master               tx
);

  localparam int NB = bytes_per_count(RESOLUTION);
  localparam int PW = NB * 8;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_HEADER = HEADER;
  localparam logic [1:0] S_FLAGS  = FLAGS;
  localparam logic [1:0] S_DATA   = DATA;

  logic [1:0]                      r_state;
  logic [CW-1:0]                   r_ch;
  logic [BW-1:0]                   r_byte;
  logic [NUM_CH-1:0][RESOLUTION-1:0] r_snap;
  logic                            r_overrun;

  logic          w_fire;
  logic          w_last_byte;
  logic          w_last_ch;
  logic [PW-1:0] w_word;
  logic [7:0]    w_data;

  assign w_fire      = tx.out_valid && tx.out_ready;
  assign w_last_byte = (r_byte == BW'(NB - 1));
  assign w_last_ch   = (r_ch == CW'(NUM_CH - 1));

  // A snapshot arriving outside IDLE (including the final-byte cycle) is dropped and flagged.
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ch      <= '0;
      r_byte    <= '0;
      r_snap    <= '0;
      r_overrun <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_load) begin
            r_snap  <= i_counts;
            r_ch    <= '0;
            r_byte  <= '0;
            r_state <= S_HEADER;
          end
        end
        S_HEADER: if (w_fire) r_state <= S_FLAGS;
        S_FLAGS:  if (w_fire) r_state <= S_DATA;
        default: begin
          if (w_fire) begin
            if (w_last_byte) begin
              r_byte <= '0;
              if (w_last_ch) r_state <= S_IDLE;
              else           r_ch    <= r_ch + CW'(1);
            end else begin
              r_byte <= r_byte + BW'(1);
            end
          end
        end
      endcase
      if (i_load && (r_state != S_IDLE)) r_overrun <= 1'b1;
    end
  end

  always_comb begin
    w_word = PW'(r_snap[r_ch]);
    w_data = 8'h00;
    case (r_state)
      S_HEADER: w_data = FRAME_HEADER;
      S_FLAGS:  w_data = {7'b0, r_overrun};
      S_DATA:   w_data = w_word[8 * (NB - 1 - int'(r_byte)) +: 8];
      default:  w_data = 8'h00;
    endcase
  end

  assign tx.out_data  = w_data;
  assign tx.out_valid = (r_state != S_IDLE);
  assign o_overrun    = r_overrun;

endmodule

// File: rtl/correlator_lag_core.sv
// Multi-lag pairwise coincidence counter: synchronises pulses, samples on a tick, integrates per window.
module correlator_lag_core
  import correlator_pkg::*;
#(
  parameter int NUM_INPUTS          = 12,
  parameter int MAX_DELAY           = 4,
  parameter int RESOLUTION          = 16,
  parameter int SAMPLE_DIV          = 50,
  parameter int INTEGRATION_SAMPLES = 1000000,
  parameter int INVERT_INPUTS       = 1
) (
  input  logic                  clki,
  input  logic                  rst_n,
  input  logic [NUM_INPUTS-1:0] pulse_in,
  input  logic                  enable,
  output logic                  sample_clk_pulse,
  output logic                  integration_clk_pulse,
  output logic                  overrun,
  correlator_lag_core_if.master tx
);

  localparam int NUM_CORRELATORS = num_pairs(NUM_INPUTS);
  localparam int NUM_CH          = NUM_CORRELATORS * MAX_DELAY;
  localparam int HD              = (MAX_DELAY > 1) ? MAX_DELAY - 1 : 1;
  localparam int DW              = $clog2(SAMPLE_DIV);
  localparam int SW              = $clog2(INTEGRATION_SAMPLES);
  localparam logic [RESOLUTION-1:0] CMAX = '1;

  logic [NUM_INPUTS-1:0]             r_sync1;
  logic [NUM_INPUTS-1:0]             r_sync2;
  logic [DW-1:0]                     r_div;
  logic [SW-1:0]                     r_samp;
  logic                              r_snap_req;
  logic [NUM_INPUTS-1:0][HD-1:0]     r_hist;
  logic [NUM_CH-1:0][RESOLUTION-1:0] r_cnt;

  logic [NUM_INPUTS-1:0]                w_s;
  logic [NUM_INPUTS-1:0][MAX_DELAY-1:0] w_h;
  logic [NUM_CH-1:0]                    w_prod;
  logic                                 w_tick;
  logic                                 w_win_end;

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= pulse_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = (INVERT_INPUTS != 0) ? ~r_sync2 : r_sync2;

  assign w_tick    = enable && (r_div == DW'(SAMPLE_DIV - 1));
  assign w_win_end = w_tick && (r_samp == SW'(INTEGRATION_SAMPLES - 1));

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      r_div      <= '0;
      r_samp     <= '0;
      r_snap_req <= 1'b0;
    end else begin
      if (enable) r_div <= w_tick ? '0 : r_div + DW'(1);
      if (w_tick) r_samp <= w_win_end ? '0 : r_samp + SW'(1);
      r_snap_req <= w_win_end;
    end
  end

  // w_h is the history as seen on the tick itself: lag 0 is the incoming sample.
  for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_ch
    assign w_h[k][0] = w_s[k];
    for (genvar d = 1; d < MAX_DELAY; d++) begin : g_lag
      assign w_h[k][d] = r_hist[k][d-1];
    end
  end

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= '0;
    end else if (w_tick) begin
      for (int k = 0; k < NUM_INPUTS; k++) r_hist[k] <= w_h[k][HD-1:0];
    end
  end

  always_comb begin
    w_prod = '0;
    for (int i = 0; i < NUM_INPUTS; i++)
      for (int j = i + 1; j < NUM_INPUTS; j++)
        for (int d = 0; d < MAX_DELAY; d++)
          w_prod[pair_index(i, j, NUM_INPUTS) * MAX_DELAY + d] = w_h[i][0] & w_h[j][d];
  end

  // Counters saturate; the cycle after a window end hands them to the readout and clears them.
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_snap_req) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      for (int c = 0; c < NUM_CH; c++)
        if (w_prod[c] && (r_cnt[c] != CMAX)) r_cnt[c] <= r_cnt[c] + RESOLUTION'(1);
    end
  end

  assign sample_clk_pulse      = w_tick;
  assign integration_clk_pulse = w_win_end;

  correlator_frame_tx #(
    .NUM_CH     (NUM_CH),
    .RESOLUTION (RESOLUTION)
  ) u_frame_tx (
    .clki      (clki),
    .rst_n     (rst_n),
    .i_load    (r_snap_req),
    .i_counts  (r_cnt),
    .o_overrun (overrun),
    .tx        (tx)
  );

endmodule
